// File: rtl/jaxa_pio_pkg.sv
// Shared definitions for the JAXA SpaceWire transmit-side PIO: register map,
// STATUS field layout and the pulse-timer state encoding.
package jaxa_pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_PULSE    = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_CNT_LSB  = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pulse_state_e;

   // Width of the pulse down-counter; a single-cycle pulse still needs one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/jaxa_pulse_timer.sv
// Self-timed pulse generator: holds the active pulse mask and keeps it asserted
// for PULSE_CYCLES cycles after the most recent non-zero load.
module jaxa_pulse_timer
   import jaxa_pio_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int PULSE_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             load_i,
   input  logic [WIDTH-1:0]                 mask_i,
   output logic [WIDTH-1:0]                 mask_o,
   output logic [WIDTH-1:0]                 mask_next_o,
   output logic                             busy_o,
   output logic [cnt_width(PULSE_CYCLES)-1:0] count_o
);

   localparam int CNT_W = cnt_width(PULSE_CYCLES);

   pulse_state_e     state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mask_q,  mask_d;

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mask_d  = mask_q;
      if (load_i && (mask_i != '0)) begin
         // Retrigger merges the new bits and restarts the full length.
         mask_d  = mask_q | mask_i;
         count_d = CNT_W'(PULSE_CYCLES - 1);
         state_d = ST_ACTIVE;
      end else if (state_q == ST_ACTIVE) begin
         if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
         end else begin
            mask_d  = '0;
            state_d = ST_IDLE;
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mask_q  <= mask_d;
      end
   end

   assign mask_o      = mask_q;
   assign mask_next_o = mask_d;
   assign busy_o      = (state_q == ST_ACTIVE);
   assign count_o     = count_q;

endmodule

// File: rtl/jaxa_transmit_control_pio.sv
// Avalon-MM output PIO for the SpaceWire transmit side: DATA register with
// set/clear aliases, self-timed pulses, and a registered read port.
module jaxa_transmit_control_pio
   import jaxa_pio_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int               PULSE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             pulse_busy
);

   localparam int CNT_W = cnt_width(PULSE_CYCLES);

   logic             wr_en;
   logic [WIDTH-1:0] wdata;
   logic             pulse_load;

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] out_port_q;
   logic [31:0]      readdata_q, readdata_d;

   logic [WIDTH-1:0] pulse_mask;
   logic [WIDTH-1:0] pulse_mask_next;
   logic             pulse_busy_w;
   logic [CNT_W-1:0] pulse_count;
   logic [31:0]      status;

   assign wr_en      = chipselect & ~write_n;
   assign wdata      = writedata[WIDTH-1:0];
   assign pulse_load = wr_en && (address == ADDR_PULSE);

   if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_bits;
      assign unused_wdata_bits = ^writedata[31:WIDTH];
   end

   jaxa_pulse_timer #(
      .WIDTH        (WIDTH),
      .PULSE_CYCLES (PULSE_CYCLES)
   ) u_pulse_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (pulse_load),
      .mask_i      (wdata),
      .mask_o      (pulse_mask),
      .mask_next_o (pulse_mask_next),
      .busy_o      (pulse_busy_w),
      .count_o     (pulse_count)
   );

   always_comb begin
      data_d = data_q;
      if (wr_en) begin
         case (address)
            ADDR_DATA:     data_d = wdata;
            ADDR_OUTSET:   data_d = data_q | wdata;
            ADDR_OUTCLEAR: data_d = data_q & ~wdata;
            default:       data_d = data_q;
         endcase
      end
   end

   always_comb begin
      status                                = '0;
      status[STATUS_BUSY_BIT]               = pulse_busy_w;
      status[STATUS_CNT_LSB +: CNT_W]       = pulse_count;
   end

   always_comb begin
      case (address)
         ADDR_DATA:   readdata_d = 32'(data_q);
         ADDR_PULSE:  readdata_d = 32'(pulse_mask);
         ADDR_STATUS: readdata_d = status;
         default:     readdata_d = '0;
      endcase
   end

   // out_port is built from next-state values so a write is visible right after
   // its accepting edge, with no extra register stage.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         out_port_q <= RESET_VALUE;
         readdata_q <= '0;
      end else begin
         data_q     <= data_d;
         out_port_q <= data_d | pulse_mask_next;
         readdata_q <= readdata_d;
      end
   end

   assign readdata   = readdata_q;
   assign out_port   = out_port_q;
   assign pulse_busy = pulse_busy_w;

endmodule
